key_frame_serializer: RTL and testbench

Converts parallel key words from the keypad/command capture logic into the serial `InputKey`/`ValidCmd` frame stream consumed by the input-key decoder. Each accepted word is shifted out MSB-first, one bit per clock, with `ValidCmd` high for exactly the frame. A one-entry holding buffer lets the producer queue the next word while the current frame is on the wire. A guaranteed idle gap separates consecutive frames.

---
 rtl/key_frame_serializer.sv | 126 ++++++++++++
 tb/tb_key_frame_serializer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/key_frame_serializer.sv
// Purpose: turns parallel key words into an MSB-first InputKey bit stream framed by ValidCmd.
// Latency: the first bit is registered on the accepting edge. Queued words follow after exactly GAP idle cycles.
// Backpressure: Ready drops while the one-word hold is occupied. A KeyLoad seen with Ready low pulses Overrun and the word is dropped.
module key_frame_serializer #(
  parameter int WIDTH = 8,
  parameter int GAP   = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] KeyData,
  input  logic             KeyLoad,
  output logic             Ready,
  output logic             InputKey,
  output logic             ValidCmd,
  output logic             Done,
  output logic             Overrun
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]    bit_cnt, bit_cnt_nxt;
  logic [GW-1:0]    gap_cnt, gap_cnt_nxt;
  logic [WIDTH-1:0] hold, hold_nxt;
  logic             hold_full, hold_full_nxt;
  logic             key_nxt, valid_nxt, done_nxt, overrun_nxt;
  logic             accept, last_bit, last_gap;

  assign Ready    = ~hold_full;
  assign accept   = KeyLoad & ~hold_full;
  assign last_bit = (bit_cnt == CW'(WIDTH - 1));
  assign last_gap = (gap_cnt == GW'(GAP - 1));

  // State, datapath and registered outputs
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= S_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      InputKey  <= 1'b0;
      ValidCmd  <= 1'b0;
      Done      <= 1'b0;
      Overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      bit_cnt   <= bit_cnt_nxt;
      gap_cnt   <= gap_cnt_nxt;
      hold      <= hold_nxt;
      hold_full <= hold_full_nxt;
      InputKey  <= key_nxt;
      ValidCmd  <= valid_nxt;
      Done      <= done_nxt;
      Overrun   <= overrun_nxt;
    end
  end

  // Next-state: frame sequencing, hold buffer fill and drain
  always_comb begin
    state_nxt     = state;
    shreg_nxt     = shreg;
    bit_cnt_nxt   = bit_cnt;
    gap_cnt_nxt   = gap_cnt;
    hold_nxt      = hold;
    hold_full_nxt = hold_full;
    // Outside IDLE a new word always parks in the hold. IDLE bypasses it.
    if (accept && (state != S_IDLE)) begin
      hold_nxt      = KeyData;
      hold_full_nxt = 1'b1;
    end
    case (state)
      S_IDLE: begin
        // A word left in the hold by a final-gap-edge load starts exactly like a fresh load.
        if (hold_full) begin
          shreg_nxt     = hold;
          hold_full_nxt = 1'b0;
          bit_cnt_nxt   = '0;
          state_nxt     = S_SHIFT;
        end else if (KeyLoad) begin
          shreg_nxt   = KeyData;
          bit_cnt_nxt = '0;
          state_nxt   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shreg_nxt   = {shreg[WIDTH-2:0], 1'b0};
        bit_cnt_nxt = bit_cnt + 1'b1;
        if (last_bit) begin
          gap_cnt_nxt = '0;
          state_nxt   = S_GAP;
        end
      end
      S_GAP: begin
        gap_cnt_nxt = gap_cnt + 1'b1;
        if (last_gap) begin
          // hold_full is the pre-edge value: a load landing on this edge waits one IDLE cycle.
          if (hold_full) begin
            shreg_nxt     = hold;
            hold_full_nxt = 1'b0;
            bit_cnt_nxt   = '0;
            state_nxt     = S_SHIFT;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from the next state
  always_comb begin
    valid_nxt   = (state_nxt == S_SHIFT);
    key_nxt     = valid_nxt & shreg_nxt[WIDTH-1];
    done_nxt    = (state == S_SHIFT) & last_bit;
    overrun_nxt = KeyLoad & hold_full;
  end

endmodule

// File: tb/tb_key_frame_serializer.sv
// Bench for key_frame_serializer: a schedule model predicts every output cycle by cycle.
// The model assigns each accepted word a start cycle from the frame/gap timing rules.
// Wire contents, Done, Ready and Overrun are then derived from that word schedule.
module tb_key_frame_serializer;
  localparam int W = 8;
  localparam int G = 2;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic [W-1:0] KeyData = '0;
  logic         KeyLoad = 1'b0;
  logic         Ready, InputKey, ValidCmd, Done, Overrun;

  key_frame_serializer #(.WIDTH(W), .GAP(G)) dut (
    .Clk(Clk), .Reset(Reset), .KeyData(KeyData), .KeyLoad(KeyLoad),
    .Ready(Ready), .InputKey(InputKey), .ValidCmd(ValidCmd), .Done(Done), .Overrun(Overrun)
  );

  always #5 Clk = ~Clk;

  // Accepted word: accept edge, first-bit cycle, payload
  typedef struct {int a; int s; logic [W-1:0] d;} word_t;
  word_t q[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [4:0] exp_v, got_v;

  // Hold occupied during cycle c: word accepted at or before c that has not started yet
  function automatic bit hold_busy(int c);
    foreach (q[i]) if (q[i].a <= c && c < q[i].s) return 1'b1;
    return 1'b0;
  endfunction

  // Expected {ValidCmd, InputKey, Done, Overrun, Ready} during cycle c
  function automatic logic [4:0] expect_out(int c, bit ovr);
    bit v = 1'b0;
    bit k = 1'b0;
    bit d = 1'b0;
    logic [W-1:0] wd;
    foreach (q[i]) begin
      if (c >= q[i].s && c < q[i].s + W) begin
        v  = 1'b1;
        wd = q[i].d;
        k  = wd[W-1-(c-q[i].s)];
      end
      if (c == q[i].s + W) d = 1'b1;
    end
    return {v, k, d, ovr, ~hold_busy(c)};
  endfunction

  // Drive one cycle, advance the model across the edge, set exp_v/got_v
  task automatic step(input bit rst, input bit ld, input logic [W-1:0] dat);
    bit rdy, ovr;
    int s, pe;
    word_t w;
    Reset = rst; KeyLoad = ld; KeyData = dat;
    rdy = ~hold_busy(cyc);
    @(posedge Clk);
    cyc++;
    ovr = 1'b0;
    if (rst) q.delete();
    else if (ld) begin
      if (!rdy) ovr = 1'b1;
      else begin
        if (q.size() == 0) s = cyc;
        else begin
          pe = q[$].s + W + G;
          if (cyc < pe) s = pe;
          else if (cyc == pe) s = cyc + 1;
          else s = cyc;
        end
        w.a = cyc; w.s = s; w.d = dat;
        q.push_back(w);
      end
    end
    #1;
    exp_v = rst ? 5'b00001 : expect_out(cyc, ovr);
    got_v = {ValidCmd, InputKey, Done, Overrun, Ready};
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({ValidCmd, InputKey, Done, Overrun, Ready} !== 5'b00001) begin
      errors++; $display("FAIL reset_t0 got %b exp 00001", {ValidCmd, InputKey, Done, Overrun, Ready});
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 8'hA5);
      checks++;
      if (got_v !== 5'b00001) begin errors++; $display("FAIL reset_hold cyc %0d got %b exp 00001", cyc, got_v); end
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 8'h00);
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL reset_release cyc %0d got %b exp %b", cyc, got_v, exp_v); end
    end
  endtask

  task automatic test_single;
    logic [W-1:0] cap;
    for (int i = 0; i < W + 12; i++) begin
      step(1'b0, i == 0, 8'hA5);
      if (i < W) cap[W-1-i] = InputKey;
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL single cyc %0d got %b exp %b", cyc, got_v, exp_v); end
    end
    checks++;
    if (cap !== 8'hA5) begin errors++; $display("FAIL single_bits got %h exp a5", cap); end
  endtask

  task automatic test_queue;
    int dones = 0;
    int vcyc = 0;
    for (int i = 0; i < 32; i++) begin
      step(1'b0, (i == 0) || (i == 3) || (i == 4), (i == 0) ? 8'hA5 : (i == 3) ? 8'h3C : 8'hFF);
      dones += int'(Done);
      vcyc  += int'(ValidCmd);
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL queue cyc %0d got %b exp %b", cyc, got_v, exp_v); end
    end
    checks++;
    if (dones != 2) begin errors++; $display("FAIL queue_done got %0d exp 2", dones); end
    checks++;
    if (vcyc != 2 * W) begin errors++; $display("FAIL queue_valid got %0d exp %0d", vcyc, 2 * W); end
  endtask

  task automatic test_reset_midframe;
    int vcyc = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, (i == 0) || (i == 2), (i == 0) ? 8'hA5 : 8'h3C);
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL midrst_pre cyc %0d got %b exp %b", cyc, got_v, exp_v); end
    end
    #3 Reset = 1'b1;
    #1;
    checks++;
    if ({ValidCmd, InputKey, Done, Overrun, Ready} !== 5'b00001) begin
      errors++; $display("FAIL midrst_async got %b exp 00001", {ValidCmd, InputKey, Done, Overrun, Ready});
    end
    step(1'b1, 1'b0, 8'h00);
    checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL midrst_hold got %b exp %b", got_v, exp_v); end
    for (int i = 0; i < 25; i++) begin
      step(1'b0, 1'b0, 8'h00);
      vcyc += int'(ValidCmd) + int'(Done);
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL midrst_post cyc %0d got %b exp %b", cyc, got_v, exp_v); end
    end
    checks++;
    if (vcyc != 0) begin errors++; $display("FAIL midrst_quiet got %0d exp 0", vcyc); end
  endtask

  task automatic test_gap_edge_load;
    logic [W-1:0] cap;
    int lows = 0;
    for (int i = 0; i < W + G + 1 + W + 6; i++) begin
      step(1'b0, (i == 0) || (i == W + G), (i == 0) ? 8'h11 : 8'h81);
      if (i >= W && i <= W + G) lows += int'(!ValidCmd);
      if (i > W + G && i <= W + G + W) cap[W + G + W - i] = InputKey;
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL gapedge cyc %0d got %b exp %b", cyc, got_v, exp_v); end
    end
    checks++;
    if (cap !== 8'h81) begin errors++; $display("FAIL gapedge_bits got %h exp 81", cap); end
    checks++;
    if (lows < G) begin errors++; $display("FAIL gapedge_lows got %0d exp >=%0d", lows, G); end
  endtask

  task automatic test_back_to_back;
    int rises[$];
    bit pv = 1'b0;
    for (int i = 0; i < 6 * (W + G) + 4; i++) begin
      step(1'b0, Ready, 8'($urandom));
      if (ValidCmd && !pv) rises.push_back(cyc);
      pv = ValidCmd;
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL b2b cyc %0d got %b exp %b", cyc, got_v, exp_v); end
    end
    for (int i = 0; i + 1 < rises.size(); i++) begin
      checks++;
      if (rises[i+1] - rises[i] != W + G) begin
        errors++; $display("FAIL b2b_period got %0d exp %0d", rises[i+1] - rises[i], W + G);
      end
    end
    for (int i = 0; i < 25; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_random;
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 35, 8'($urandom));
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL random cyc %0d got %b exp %b", cyc, got_v, exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_queue();
    test_reset_midframe();
    test_gap_edge_load();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
